and_08_sequencer: RTL and testbench

Controller that shares one 74xx08 quad AND gate model (`and_08`, 4-bit `a`/`b` in, 4-bit `y` out) between two requesters. It executes each 8-bit AND as two sequential nibble passes through the single chip. It sits in the emulator's ALU logic path as the scheduling front-end of the AND unit. It arbitrates round-robin, registers operands at acceptance, and returns an 8-bit result with a one-cycle acknowledge.

---
 rtl/and_08_sequencer.sv | 158 +++++++++++++++
 tb/tb_and_08_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/and_08_sequencer.sv
// -----------------------------------------------------------------------------
// and_08_sequencer
//
// Scheduling front-end of the emulator's AND unit. Two requesters share a
// single 74xx08 quad AND gate model (and_08). Each 8-bit AND is executed as
// two nibble passes through that one chip: low nibble in LO, high nibble in HI.
// Requests are arbitrated round-robin and operands are registered at
// acceptance.
//
// Handshake: a requester raises reqN and holds it, with stable aN/bN, until it
// sees ackN. Operands are sampled only at the accepting edge, which is an edge
// taken in IDLE. ackN is a one-cycle pulse during DONE, and y holds the full
// result for that whole cycle. Keeping reqN high after ackN counts as a new
// request at the next IDLE edge. Requests seen outside IDLE are not queued.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   req0/req1  in   request from requester 0 / 1
//   a0/b0      in   [7:0] operands of requester 0
//   a1/b1      in   [7:0] operands of requester 1
//   ack0/ack1  out  one-cycle "y holds your result" pulse
//   y          out  [7:0] result register
//   busy       out  high while an operation is in flight (LO, HI, DONE)
//   grant      out  index of the requester being served (valid while busy)
//   dbg_state  out  [1:0] current FSM state (0 IDLE, 1 LO, 2 HI, 3 DONE)
// -----------------------------------------------------------------------------

// Quad 2-input AND (74xx08 model). Plain 4-state AND, so X behaviour passes
// through unchanged: 0 & X = 0, 1 & X = X.
module and_08 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] y
);
   assign y = a & b;
endmodule

module and_08_sequencer #(
   parameter bit FIRST_GRANT = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic [7:0] a0,
   input  logic [7:0] b0,
   output logic       ack0,
   input  logic       req1,
   input  logic [7:0] a1,
   input  logic [7:0] b1,
   output logic       ack1,
   output logic [7:0] y,
   output logic       busy,
   output logic       grant,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t     state_q;
   logic [7:0] op_a_q;
   logic [7:0] op_b_q;
   logic [7:0] y_q;
   logic       grant_q;
   logic       last_grant_q;

   logic       win_d;
   logic [3:0] gate_a;
   logic [3:0] gate_b;
   logic [3:0] gate_y;

   // Round-robin: a lone request wins outright; on contention the requester
   // that was not served last wins.
   always_comb begin
      win_d = 1'b0;
      if (req0 && req1) begin
         win_d = ~last_grant_q;
      end else if (req1) begin
         win_d = 1'b1;
      end
   end

   // Gate inputs come only from the operand registers, one nibble per state,
   // so X bits in one nibble can never reach the other nibble's write.
   always_comb begin
      gate_a = 4'b0000;
      gate_b = 4'b0000;
      case (state_q)
         LO: begin
            gate_a = op_a_q[3:0];
            gate_b = op_b_q[3:0];
         end
         HI: begin
            gate_a = op_a_q[7:4];
            gate_b = op_b_q[7:4];
         end
         default: begin
            gate_a = 4'b0000;
            gate_b = 4'b0000;
         end
      endcase
   end

   and_08 u_and_08 (
      .a (gate_a),
      .b (gate_b),
      .y (gate_y)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         op_a_q       <= 8'h00;
         op_b_q       <= 8'h00;
         y_q          <= 8'h00;
         grant_q      <= 1'b0;
         last_grant_q <= ~FIRST_GRANT;
      end else begin
         case (state_q)
            IDLE: begin
               if (req0 || req1) begin
                  grant_q <= win_d;
                  op_a_q  <= win_d ? a1 : a0;
                  op_b_q  <= win_d ? b1 : b0;
                  state_q <= LO;
               end
            end
            LO: begin
               y_q[3:0] <= gate_y;
               state_q  <= HI;
            end
            HI: begin
               y_q[7:4] <= gate_y;
               state_q  <= DONE;
            end
            DONE: begin
               last_grant_q <= grant_q;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Acks are decoded from state so they line up exactly with DONE.
   assign ack0      = (state_q == DONE) && !grant_q;
   assign ack1      = (state_q == DONE) &&  grant_q;
   assign busy      = (state_q != IDLE);
   assign grant     = grant_q;
   assign y         = y_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_and_08_sequencer.sv
module tb_and_08_sequencer;

   logic       clk;
   logic       reset;
   logic       req0, req1;
   logic [7:0] a0, b0, a1, b1;
   logic       ack0, ack1;
   logic [7:0] y;
   logic       busy;
   logic       grant;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   // Scoreboard entries: {requester index, expected 8-bit result}.
   logic [8:0] exp_q[$];

   and_08_sequencer #(.FIRST_GRANT(1'b0)) dut (
      .clk       (clk),
      .reset     (reset),
      .req0      (req0),
      .a0        (a0),
      .b0        (b0),
      .ack0      (ack0),
      .req1      (req1),
      .a1        (a1),
      .b1        (b1),
      .ack1      (ack1),
      .y         (y),
      .busy      (busy),
      .grant     (grant),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // ---------------- driver tasks ----------------
   // All driving and sampling happens on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   // Wait (bounded) for an ack; returns the number of falling edges waited.
   task automatic wait_ack(input int budget, output int waited, output logic ok);
      waited = 0;
      ok = 1'b0;
      while (waited < budget && !ok) begin
         tick();
         waited++;
         if (ack0 || ack1) ok = 1'b1;
      end
      if (!ok) check("ack_timeout", 8'd0, 8'd1);
   endtask

   // Pop the scoreboard and compare against the current ack cycle.
   task automatic score(input string tag);
      logic [8:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 8'd0, 8'd1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_grant"}, {7'd0, grant}, {7'd0, e[8]});
         check({tag, "_ack"},   {6'd0, ack1, ack0}, e[8] ? 8'd2 : 8'd1);
         check({tag, "_y"},     y, e[7:0]);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int   w;
      logic ok;
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;

      // Reset held 2 cycles with both requests high; also sets up contention.
      tick();
      req0 = 1'b1; a0 = 8'hFF; b0 = 8'h0F;
      req1 = 1'b1; a1 = 8'hAA; b1 = 8'hFF;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_ack",  {6'd0, ack1, ack0}, 8'd0);
         check("rst_busy", {7'd0, busy}, 8'd0);
         check("rst_y",    y, 8'h00);
         check("rst_grant", {7'd0, grant}, 8'd0);
      end
      reset = 1'b0;

      // Contention: requester 0 wins first after reset, requester 1 exactly 4 later.
      exp_q.push_back({1'b0, 8'h0F});
      exp_q.push_back({1'b1, 8'hAA});
      tick();
      check("cont_accept_busy", {7'd0, busy}, 8'd1);
      check("cont_accept_grant", {7'd0, grant}, 8'd0);
      wait_ack(10, w, ok);
      check("cont_lat0", 8'(w), 8'd2);
      score("cont0");
      req0 = 1'b0;
      wait_ack(10, w, ok);
      check("cont_gap", 8'(w), 8'd4);
      score("cont1");
      req1 = 1'b0;
      tick();
      check("cont_idle_busy", {7'd0, busy}, 8'd0);
      tick();

      // Single request; a0 changed after acceptance must not matter.
      req0 = 1'b1; a0 = 8'hF0; b0 = 8'h3C;
      tick();  // acceptance edge has passed: cycle k+1
      check("single_busy1", {7'd0, busy}, 8'd1);
      check("single_noack1", {6'd0, ack1, ack0}, 8'd0);
      a0 = 8'h00;
      tick();
      check("single_busy2", {7'd0, busy}, 8'd1);
      check("single_noack2", {6'd0, ack1, ack0}, 8'd0);
      tick();
      check("single_busy3", {7'd0, busy}, 8'd1);
      check("single_ack", {6'd0, ack1, ack0}, 8'd1);
      check("single_y", y, 8'h30);
      req0 = 1'b0;
      tick();
      check("single_done_busy", {7'd0, busy}, 8'd0);
      check("single_done_ack", {6'd0, ack1, ack0}, 8'd0);
      check("single_y_hold", y, 8'h30);

      // Fairness: reset restores last_grant so requester 0 goes first.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req0 = 1'b1; a0 = 8'h33; b0 = 8'hF0;
      req1 = 1'b1; a1 = 8'hC5; b1 = 8'h0F;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back((i % 2 == 0) ? {1'b0, 8'h30} : {1'b1, 8'h05});
      end
      for (int i = 0; i < 5; i++) begin
         wait_ack(10, w, ok);
         if (i == 0) check("fair_lat", 8'(w), 8'd3);
         else        check("fair_gap", 8'(w), 8'd4);
         score("fair");
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
      tick();

      // Reset during HI: operation abandoned, y cleared, no ack afterwards.
      req0 = 1'b1; a0 = 8'h12; b0 = 8'hFF;
      tick();  // LO
      tick();  // HI
      check("midrst_state_hi", {6'd0, dbg_state}, 8'd2);
      reset = 1'b1; req0 = 1'b0;
      tick();
      check("midrst_ack", {6'd0, ack1, ack0}, 8'd0);
      check("midrst_busy", {7'd0, busy}, 8'd0);
      check("midrst_y", y, 8'h00);
      check("midrst_state", {6'd0, dbg_state}, 8'd0);
      reset = 1'b0;
      req1 = 1'b1; a1 = 8'h5A; b1 = 8'hFF;
      exp_q.push_back({1'b1, 8'h5A});
      wait_ack(10, w, ok);
      check("midrst_new_lat", 8'(w), 8'd3);
      score("midrst_new");
      req1 = 1'b0;
      tick();
      tick();

      // X in the high nibble of a0.
      req0 = 1'b1; a0 = 8'bxxxx_1111; b0 = 8'h0F;
      exp_q.push_back({1'b0, 8'h0F});
      wait_ack(10, w, ok);
      score("x_mask");
      req0 = 1'b0;
      tick();
      req0 = 1'b1; b0 = 8'hFF;
      wait_ack(10, w, ok);
      check("x_pass_ack", {6'd0, ack1, ack0}, 8'd1);
      check("x_pass_lo", {4'd0, y[3:0]}, 8'h0F);
      req0 = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
